// File: rtl/demux_pkg.sv
// Shared types and constants for the demux dispatch slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/demux_wait_ctr.sv
// Wait counter: counts enabled cycles since clear, flags the last allowed cycle.
// Latency: expired is a decode of the registered count (same cycle).
// Backpressure: none; caller decides when to clear/enable.
module demux_wait_ctr
    import demux_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Count stalled cycles; clear has priority so a new item always starts at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/demux_dispatch.sv
// One-entry feeder for the 1:8 demux: holds an item, steers it by address or round-robin.
// Latency: item accepted at edge k is presented on sel/out_data/out_valid in cycle k+1.
// Backpressure: in_ready follows the selected channel's ready; stalled items drop after TIMEOUT cycles.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_dest,
    input  logic              mode,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out_data,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  sent_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic             hold;
    logic             chan_rdy;
    logic             accept;
    logic             deliver;
    logic             expired;
    logic             drop;

    assign hold     = (state == HOLD);
    assign chan_rdy = out_ready[sel];
    assign deliver  = hold & chan_rdy;
    // Gated by rst_n so upstream never sees ready while the block is held in reset.
    assign in_ready = rst_n & (~hold | chan_rdy);
    assign accept   = in_valid & in_ready;
    // Delivery wins over expiry: drop only when the channel is still not ready.
    assign drop     = hold & ~chan_rdy & expired;

    demux_wait_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept | ~hold),
        .enable  (hold & ~chan_rdy),
        .expired (expired)
    );

    // One-hot valid toward the selected channel while an item is held.
    always_comb begin
        out_valid      = '0;
        out_valid[sel] = hold;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a same-cycle accept keeps us in HOLD with the new item.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = HOLD;
            end
            HOLD: begin
                if (accept)       state_nxt = HOLD;
                else if (deliver) state_nxt = IDLE;
                else if (drop)    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Held item capture, channel select, round-robin pointer and event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel      <= '0;
            out_data <= '0;
            rr_ptr   <= '0;
            sent_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                out_data <= in_data;
                sel      <= mode ? rr_ptr : in_dest;
                if (mode) rr_ptr <= rr_ptr + 3'd1;
            end
            if (deliver) sent_cnt <= sat_inc(sent_cnt);
            if (drop)    drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed bench for demux_dispatch with a scoreboard queue and a decoupled monitor.
// Stimulus drives 1ns after rising edges; the monitor samples on falling edges.
// Each queued entry is either a delivery (sel/data) or an expected timeout drop.
module tb_demux_dispatch;

    localparam int TMO = 16;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        bit         drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [2:0]  in_dest;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] drop_cnt;
    logic [15:0] sent_cnt;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] prev_drop = '0;

    demux_dispatch #(
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one item and let it be accepted at the next edge; returns 1ns after that edge.
    task automatic send(input logic m, input logic [2:0] d, input logic [7:0] dat,
                        input logic [7:0] rdy, input logic [2:0] esel, input bit edrop);
        exp_t e;
        e.sel  = esel;
        e.data = dat;
        e.drop = edrop;
        exp_q.push_back(e);
        in_valid  = 1'b1;
        mode      = m;
        in_dest   = d;
        in_data   = dat;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every delivery or drop must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (|(out_valid & out_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", {24'h0, out_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_kind_delivery", {31'h0, e.drop}, 32'h0);
                    chk("mon_sel", {29'h0, sel}, {29'h0, e.sel});
                    chk("mon_data", {24'h0, out_data}, {24'h0, e.data});
                    chk("mon_onehot", {24'h0, out_valid}, 32'h1 << e.sel);
                end
            end
            if (drop_cnt > prev_drop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_drop", {16'h0, drop_cnt}, {16'h0, prev_drop});
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_kind_drop", {31'h0, e.drop}, 32'h1);
                end
            end
        end
        prev_drop = drop_cnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        mode      = 1'b0;
        out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {24'h0, out_valid}, 32'h0);
        chk("rst_sel", {29'h0, sel}, 32'h0);
        chk("rst_sent", {16'h0, sent_cnt}, 32'h0);
        chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'h0, in_ready}, 32'h1);

        // Addressed pass-through
        send(1'b0, 3'd5, 8'hA5, 8'hFF, 3'd5, 1'b0);
        #1;
        chk("addr_sel", {29'h0, sel}, 32'd5);
        chk("addr_out_valid", {24'h0, out_valid}, 32'h20);
        chk("addr_out_data", {24'h0, out_data}, 32'hA5);
        @(posedge clk);
        #1;
        chk("addr_sent", {16'h0, sent_cnt}, 32'd1);

        // Round-robin wrap, back-to-back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.sel  = 3'(i % 8);
            e.data = 8'(i);
            e.drop = 1'b0;
            exp_q.push_back(e);
            in_valid  = 1'b1;
            mode      = 1'b1;
            in_dest   = 3'd6;
            in_data   = 8'(i);
            out_ready = 8'hFF;
            #1;
            chk("rr_in_ready", {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_sent", {16'h0, sent_cnt}, 32'd10);

        // Backpressure on channel 3; other channels ready but ignored
        do_reset();
        send(1'b0, 3'd3, 8'h33, 8'hF7, 3'd3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_out_valid", {24'h0, out_valid}, 32'h08);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        out_ready = 8'hFF;
        #1;
        chk("bp_out_valid_last", {24'h0, out_valid}, 32'h08);
        chk("bp_in_ready_last", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("bp_idle", {24'h0, out_valid}, 32'h0);
        chk("bp_sent", {16'h0, sent_cnt}, 32'd1);
        chk("bp_drop", {16'h0, drop_cnt}, 32'd0);

        // Timeout on channel 2
        do_reset();
        send(1'b0, 3'd2, 8'h22, 8'hFB, 3'd2, 1'b1);
        for (int c = 1; c <= TMO; c++) begin
            #1;
            chk("to_out_valid", {24'h0, out_valid}, 32'h04);
            if (c == TMO) chk("to_in_ready_expiry", {31'h0, in_ready}, 32'h0);
            @(posedge clk);
            #1;
        end
        chk("to_idle", {24'h0, out_valid}, 32'h0);
        chk("to_drop", {16'h0, drop_cnt}, 32'd1);
        chk("to_sent", {16'h0, sent_cnt}, 32'd0);
        chk("to_in_ready", {31'h0, in_ready}, 32'h1);

        // Ready arrives on the expiry cycle: delivery wins
        do_reset();
        send(1'b0, 3'd2, 8'h5C, 8'h00, 3'd2, 1'b0);
        repeat (TMO - 1) begin
            @(posedge clk);
            #1;
        end
        out_ready = 8'h04;
        #1;
        chk("exp_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("exp_sent", {16'h0, sent_cnt}, 32'd1);
        chk("exp_drop", {16'h0, drop_cnt}, 32'd0);
        chk("exp_idle", {24'h0, out_valid}, 32'h0);

        // Reset while holding an item; round-robin pointer must restart at 0
        do_reset();
        send(1'b1, 3'd7, 8'h10, 8'hFF, 3'd0, 1'b0);
        send(1'b1, 3'd7, 8'h11, 8'hFF, 3'd1, 1'b0);
        send(1'b1, 3'd7, 8'h12, 8'hFF, 3'd2, 1'b0);
        @(posedge clk);
        #1;
        send(1'b0, 3'd6, 8'h66, 8'h00, 3'd6, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_hold_valid", {24'h0, out_valid}, 32'h40);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mr_out_valid", {24'h0, out_valid}, 32'h0);
        chk("mr_sel", {29'h0, sel}, 32'h0);
        chk("mr_out_data", {24'h0, out_data}, 32'h0);
        chk("mr_sent", {16'h0, sent_cnt}, 32'h0);
        chk("mr_drop", {16'h0, drop_cnt}, 32'h0);
        chk("mr_in_ready", {31'h0, in_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_in_ready", {31'h0, in_ready}, 32'h1);
        send(1'b1, 3'd5, 8'h77, 8'hFF, 3'd0, 1'b0);
        #1;
        chk("mr_rr_sel", {29'h0, sel}, 32'h0);
        chk("mr_rr_valid", {24'h0, out_valid}, 32'h01);
        @(posedge clk);
        #1;
        chk("mr_rr_sent", {16'h0, sent_cnt}, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_dispatch.md
# demux_dispatch

- Upstream feeder for the 1-to-8 demultiplexer stage. Accepts a valid/ready data stream and holds each item in a one-entry register.
- Drives the 3-bit select and data toward one of 8 destination channels, in either addressed or round-robin mode.
- Waits for that channel's ready. If the channel never responds, drops the item after a programmable timeout and counts the drop.

## Interface
Parameters:
- DATA_W, 8, payload width
- TIMEOUT, 16, max cycles to wait for a destination ready (1..65535)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream item present
- in_ready  out  1  block can accept an item this cycle
- in_data  in  DATA_W  payload
- in_dest  in  3  destination channel; used only when mode=0
- mode  in  1  0 = addressed (in_dest), 1 = round-robin (internal pointer)
- sel  out  3  channel select to the demux stage
- out_data  out  DATA_W  held payload
- out_valid  out  8  one-hot; bit sel set while an item is held
- out_ready  in  8  per-channel ready
- drop_cnt  out  16  saturating count of timed-out items
- sent_cnt  out  16  saturating count of delivered items

## Operation
- States: IDLE (no item held), HOLD (item held, waiting for out_ready[sel]).
- Accept condition: in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready[sel]). This gives pass-through at 1 item/cycle.
- On accept:
  - out_data <= in_data.
  - sel <= mode ? rr_ptr : in_dest.
  - Wait counter <= 0. State goes to HOLD.
- Round-robin pointer: rr_ptr advances by 1 (mod 8, 7->0 wrap) on each accept while mode=1. It is frozen while mode=0.
- Delivery:
  - In HOLD with out_ready[sel]=1, the item transfers and sent_cnt increments (saturates at 0xFFFF).
  - If an accept occurs in the same cycle, the block stays in HOLD with the new item. Otherwise it goes to IDLE.
- Timeout:
  - In HOLD with out_ready[sel]=0, the wait counter increments.
  - When it reaches TIMEOUT-1 and out_ready[sel] is still 0, the item is discarded, drop_cnt increments (saturates), and the block goes to IDLE.
  - in_ready is 0 in that cycle.
- Simultaneous ready and timeout expiry: delivery wins; no drop.
- out_valid = (state==HOLD) ? (8'b1 << sel) : 0. Ready on channels other than sel is ignored.
- A mode or in_dest change during HOLD does not affect the held item. It applies to the next accept only.
- Reset (rst_n=0 at a clock edge, including mid-HOLD):
  - state=IDLE, held item discarded.
  - sel=0, out_data=0, out_valid=0, rr_ptr=0, wait counter=0, drop_cnt=0, sent_cnt=0.
  - in_ready=0 during reset, 1 in the first cycle after release.

## Timing
- All state and outputs are registered, except in_ready and out_valid, which decode from registered state and out_ready.
- Latency: an item accepted at edge k appears on sel/out_data/out_valid in cycle k+1.
- Throughput: 1 item/cycle with out_ready[sel] held high.
- Drop timing: an item accepted at edge k and never acknowledged is dropped at edge k+TIMEOUT. drop_cnt is visible in cycle k+TIMEOUT+1.
- Counters update on the edge of the event and are visible the next cycle.

## Structure
- Shared package demux_pkg:
  - N_CH=8, SEL_W=3.
  - State enum {IDLE, HOLD}.
  - CNT_W=16.
- One natural sub-module: demux_wait_ctr.
  - Inputs: clear, enable.
  - Output: expired at TIMEOUT-1.
  - Reused for any future per-channel timeouts.
- Saturating counters stay inline.

## Test plan
- Addressed pass-through: mode=0, in_dest=5, data 0xA5, out_ready=8'hFF -> next cycle sel=5, out_valid=8'h20, out_data=0xA5; sent_cnt=1.
- Round-robin wrap: mode=1, 10 back-to-back items 0x00..0x09, all ready -> sel sequence 0,1,..,7,0,1; in_ready constantly 1; sent_cnt=10.
- Backpressure: dest 3, out_ready[3]=0 for 5 cycles (TIMEOUT=16), then 1 -> out_valid=8'h08 held stable 6 cycles; in_ready=0 until the ready cycle; no drop.
- Timeout: dest 2, out_ready=0 always, TIMEOUT=16 -> item dropped at edge k+16; drop_cnt=1; state IDLE; in_ready=1 next cycle.
- Ready on the expiry cycle: out_ready[2] rises exactly at wait count 15 -> delivery; sent_cnt=1, drop_cnt=0.
- Reset mid-HOLD: assert rst_n=0 with an item held -> next cycle out_valid=0, sel=0, counters 0. After release, the first round-robin item goes to channel 0.
